// File: rtl/icache_op_engine_pkg.sv
// Shared definitions for the I-cache maintenance-op engine.
// Holds the op-code constants, the FSM state type and the tag-entry width helper.
package icache_op_engine_pkg;

    localparam int unsigned DEF_PABITS = 36;

    localparam logic [2:0] ICOP_IDX_INV   = 3'd0;
    localparam logic [2:0] ICOP_IDX_LDTAG = 3'd1;
    localparam logic [2:0] ICOP_IDX_STTAG = 3'd2;
    localparam logic [2:0] ICOP_HIT_INV   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_EVAL,
        ST_WRITE,
        ST_DONE
    } state_t;

    // A tag-array entry is {valid, tag}, where the tag is PABITS-10 bits wide.
    function automatic int unsigned tag_entry_w(input int unsigned pabits);
        return pabits - 9;
    endfunction

endpackage

// File: rtl/icache_op_engine_if.sv
// Cache-op request/response bundle between the first-fetch pipeline register
// and the cache-op engine.
//   master (fetch pipeline): drives F1_DoICacheOp, F1_ICacheOp, F1_ICacheOpData,
//                            F1_PC, F2_Flush; receives Op_Busy, Op_Done,
//                            TagLo_Data, TagLo_Valid.
//   slave  (op engine):      the reverse.
interface icache_op_engine_if
    import icache_op_engine_pkg::*;
#(
    parameter int unsigned PABITS = DEF_PABITS
);
    localparam int unsigned TAG_W = PABITS - 10;
    localparam int unsigned ENT_W = tag_entry_w(PABITS);

    logic             F1_DoICacheOp;
    logic [2:0]       F1_ICacheOp;
    logic [TAG_W-1:0] F1_ICacheOpData;
    logic [31:0]      F1_PC;
    logic             F2_Flush;
    logic             Op_Busy;
    logic             Op_Done;
    logic [ENT_W-1:0] TagLo_Data;
    logic             TagLo_Valid;

    modport master (
        output F1_DoICacheOp, F1_ICacheOp, F1_ICacheOpData, F1_PC, F2_Flush,
        input  Op_Busy, Op_Done, TagLo_Data, TagLo_Valid
    );

    modport slave (
        input  F1_DoICacheOp, F1_ICacheOp, F1_ICacheOpData, F1_PC, F2_Flush,
        output Op_Busy, Op_Done, TagLo_Data, TagLo_Valid
    );

endinterface

// File: rtl/icache_op_engine_tag_compare.sv
// 2-way tag match for HitInvalidate.
//   rdata0/rdata1 : {valid, tag} read from each way
//   cmp_tag       : physical tag to compare
//   hit           : per-way hit vector (valid & tag equal)
module icache_tag_compare
    import icache_op_engine_pkg::*;
#(
    parameter int unsigned PABITS = DEF_PABITS,
    localparam int unsigned ENT_W = tag_entry_w(PABITS)
) (
    input  logic [ENT_W-1:0] rdata0,
    input  logic [ENT_W-1:0] rdata1,
    input  logic [ENT_W-2:0] cmp_tag,
    output logic [1:0]       hit
);

    always_comb begin
        hit[0] = rdata0[ENT_W-1] && (rdata0[ENT_W-2:0] == cmp_tag);
        hit[1] = rdata1[ENT_W-1] && (rdata1[ENT_W-2:0] == cmp_tag);
    end

endmodule

// File: rtl/icache_op_engine.sv
// I-cache maintenance-op engine (second fetch stage).
// Accepts a cache op from the F1 register, sequences it against the tag array
// and stalls fetch until the op retires.
//   clock, reset           : clock, synchronous active-low reset
//   op (slave)             : op request bundle, stall, retire and TagLo result
//   Fill_Busy              : refill controller owns the tag array
//   Tag_Addr/WE/WData      : tag array index, per-way write enable, {valid, tag}
//   Tag_RData0/Tag_RData1  : per-way {valid, tag}, one cycle after Tag_Addr
module icache_op_engine
    import icache_op_engine_pkg::*;
#(
    parameter int unsigned PABITS     = DEF_PABITS,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned WAY_BIT    = 13,
    localparam int unsigned TAG_W     = PABITS - 10,
    localparam int unsigned ENT_W     = tag_entry_w(PABITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    icache_op_engine_if.slave     op,
    input  logic                  Fill_Busy,
    output logic [INDEX_BITS-1:0] Tag_Addr,
    output logic [1:0]            Tag_WE,
    output logic [ENT_W-1:0]      Tag_WData,
    input  logic [ENT_W-1:0]      Tag_RData0,
    input  logic [ENT_W-1:0]      Tag_RData1
);

    state_t                state_q, state_d;
    logic [2:0]            op_q;
    logic [INDEX_BITS-1:0] idx_q;
    logic                  way_q;
    logic [TAG_W-1:0]      data_q;
    logic [1:0]            hit_q;
    logic [ENT_W-1:0]      taglo_q;
    logic [1:0]            hit;
    logic                  accept;
    logic                  unused_pc;

    // Only index and way bits of the PC matter here.
    assign unused_pc = ^op.F1_PC;

    assign accept = (state_q == ST_IDLE) && op.F1_DoICacheOp && !op.F2_Flush;

    icache_tag_compare #(.PABITS(PABITS)) u_cmp (
        .rdata0  (Tag_RData0),
        .rdata1  (Tag_RData1),
        .cmp_tag (data_q),
        .hit     (hit)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            idx_q   <= '0;
            way_q   <= 1'b0;
            data_q  <= '0;
            hit_q   <= '0;
            taglo_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op.F1_ICacheOp;
                idx_q  <= op.F1_PC[INDEX_BITS+4:5];
                way_q  <= op.F1_PC[WAY_BIT];
                data_q <= op.F1_ICacheOpData;
            end
            if (state_q == ST_EVAL) begin
                hit_q <= hit;
                if (op_q == ICOP_IDX_LDTAG)
                    taglo_q <= way_q ? Tag_RData1 : Tag_RData0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        Tag_WE    = '0;
        Tag_WData = '0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!Fill_Busy) begin
                    case (op_q)
                        ICOP_IDX_LDTAG, ICOP_HIT_INV: state_d = ST_READ;
                        ICOP_IDX_INV, ICOP_IDX_STTAG: state_d = ST_WRITE;
                        default:                      state_d = ST_DONE;
                    endcase
                end
            end
            ST_READ: state_d = ST_EVAL;
            ST_EVAL: begin
                if (op_q == ICOP_HIT_INV && hit != 2'b00)
                    state_d = ST_WRITE;
                else
                    state_d = ST_DONE;
            end
            ST_WRITE: begin
                // HitInvalidate clears every hitting way; index ops use the PC way.
                if (op_q == ICOP_HIT_INV)
                    Tag_WE = hit_q;
                else
                    Tag_WE = way_q ? 2'b10 : 2'b01;
                if (op_q == ICOP_IDX_STTAG)
                    Tag_WData = {1'b1, data_q};
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign Tag_Addr       = idx_q;
    assign op.Op_Busy     = accept || !(state_q == ST_IDLE || state_q == ST_DONE);
    assign op.Op_Done     = (state_q == ST_DONE);
    assign op.TagLo_Valid = (state_q == ST_DONE) && (op_q == ICOP_IDX_LDTAG);
    assign op.TagLo_Data  = taglo_q;

endmodule

// File: doc/icache_op_engine.md
Name: icache_op_engine

Overview:
- Executes instruction-cache maintenance operations at the far end of the fetch pipeline, in the second fetch stage.
- Consumes the do-op / op-code / op-data / PC bundle that the first-fetch pipeline register delivers.
- Sequences each op against the I-cache tag array and holds a fetch stall until the op retires.
- Returns the Index Load Tag result to the CP0 TagLo path and pulses completion, so that the restart issued behind the op fetches against updated tags.

Parameters:
- PABITS, 36, physical address width; tag/op-data width is PABITS-10.
- INDEX_BITS, 8, set-index width; index = F1_PC[INDEX_BITS+4:5] (32 B lines).
- WAY_BIT, 13, F1_PC bit selecting the way (2-way) for index-type ops.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- F1_DoICacheOp  in  1  cache-op request valid.
- F1_ICacheOp  in  3  op code: 0 IndexInvalidate, 1 IndexLoadTag, 2 IndexStoreTag, 4 HitInvalidate, others no-op.
- F1_ICacheOpData  in  PABITS-10  tag for StoreTag; physical compare tag for HitInvalidate.
- F1_PC  in  32  op address (index, way).
- F2_Flush  in  1  pipeline flush.
- Fill_Busy  in  1  line-refill controller owns the tag array.
- Tag_Addr  out  INDEX_BITS  tag array set index.
- Tag_WE  out  2  per-way write enable.
- Tag_WData  out  PABITS-9  {valid, tag}.
- Tag_RData0  in  PABITS-9  way0 {valid, tag}; 1-cycle read latency.
- Tag_RData1  in  PABITS-9  way1 {valid, tag}; 1-cycle read latency.
- Op_Busy  out  1  stall request to the fetch stages.
- Op_Done  out  1  one-cycle retire pulse.
- TagLo_Data  out  PABITS-9  IndexLoadTag result.
- TagLo_Valid  out  1  one-cycle pulse with TagLo_Data.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; Tag_WE=0, Op_Busy=0, Op_Done=0, TagLo_Valid=0, TagLo_Data=0.
  - Reset mid-op aborts with no tag write.
- Accept condition: state IDLE & F1_DoICacheOp & ~F2_Flush.
  - Registers op, index, way and data.
  - F2_Flush in the same cycle blocks acceptance. Once accepted, flush is ignored and the op always completes.
  - Requests while not IDLE are ignored.
- States:
  - IDLE: accept moves to WAIT.
  - WAIT: hold while Fill_Busy. When clear, go to READ for ops 1 and 4, WRITE for ops 0 and 2, DONE for no-ops.
  - READ: drive Tag_Addr → EVAL.
  - EVAL: RData valid.
    - Op 1: capture the selected way into TagLo_Data → DONE.
    - Op 4: hit = valid & tag==data per way. Any hit → WRITE (only hitting ways), else → DONE.
  - WRITE: Tag_WE asserted for exactly 1 cycle.
    - Op 0 / op 4: valid=0, tag=0.
    - Op 2: valid=1, tag=data.
    - → DONE.
  - DONE: Op_Done=1; TagLo_Valid=1 if op 1 → IDLE.
- Tag_Addr holds the registered index in every state except IDLE (don't-care in IDLE).
- Op_Busy = accept | (state ∉ {IDLE, DONE}). The stall drops in the DONE cycle so the restart advances.
- Latency with Fill_Busy=0, from the accept cycle T:
  - StoreTag/IndexInvalidate: WE at T+2, Done at T+3.
  - LoadTag: Done and TagLo at T+4.
  - HitInvalidate: WE at T+4, Done at T+5; on miss, Done at T+4.
  - No-op: Done at T+2.
- Hit in both ways (corrupt state) invalidates both.
- Back-to-back ops: the next accept is possible in the IDLE cycle right after DONE.

Decomposition:
- Shared package holds:
  - op-code constants (ICOP_IDX_INV=0, ICOP_IDX_LDTAG=1, ICOP_IDX_STTAG=2, ICOP_HIT_INV=4);
  - state encodings;
  - tag-entry width PABITS-9.
- One sub-module: icache_tag_compare (2-way valid/tag match → hit vector).

Test Plan:
- StoreTag, PC=0x0000_2040, data=0x1234 → T+2: Tag_Addr=0x02, Tag_WE=2'b10, WData={1,0x1234}; T+3: Op_Done=1; Op_Busy high T..T+2.
- LoadTag, PC=0x0000_0060, RData0={1,0xABC} → T+4: TagLo_Valid=1, TagLo_Data={1,0xABC}; Tag_WE never asserted.
- HitInvalidate, data=0x55, RData1={1,0x55}, RData0={1,0x77} → T+4: Tag_WE=2'b10, WData=0; same with both mismatching → no WE, Op_Done at T+4.
- Fill_Busy=1 for 5 cycles at accept → stays in WAIT with Op_Busy=1, then IndexInvalidate WE 2 cycles after Fill_Busy falls.
- F2_Flush with the request → no accept, Op_Busy=0; flush during READ → op still completes with Op_Done.
- reset=0 during WRITE-bound WAIT → no Tag_WE, all outputs 0 next cycle; op code 7 → Op_Done at T+2, no tag access.
